// File: rtl/hazard_tracker_pkg.sv
`default_nettype none
// ============================================================================
// Module   : hazard_pkg
// Brief    : Shared constants and helpers for the decode-stage hazard tracker.
// Revision : 1.0 - initial release
// ============================================================================
package hazard_pkg;

    localparam logic [1:0] TUSE_NONE = 2'd3;
    localparam logic [1:0] TNEW_ALU  = 2'd1;
    localparam logic [1:0] TNEW_LOAD = 2'd2;
    localparam logic [1:0] TNEW_LINK = 2'd0;
    localparam logic [2:0] FWD_RF    = 3'd0;

    function automatic logic [1:0] sat_dec(input logic [1:0] t);
        return (t == 2'd0) ? 2'd0 : t - 2'd1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/hazard_tracker_md_busy_counter.sv
`default_nettype none
// ============================================================================
// Module   : md_busy_counter
// Brief    : Occupancy down-counter for the multi-cycle mult/div unit.
// Revision : 1.0 - initial release
// ============================================================================
module md_busy_counter #(
    parameter int MULT_CYC = 5,
    parameter int DIV_CYC  = 10
) (
    input  logic start,
    input  logic is_div,
    output logic busy,
    input  logic clk,
    input  logic reset
);

    localparam logic [7:0] c_mult_load = 8'(MULT_CYC);
    localparam logic [7:0] c_div_load  = 8'(DIV_CYC);

    logic [7:0] r_cnt;

    // A new start reloads outright; the decode stall guarantees it only
    // arrives once the previous operation has drained.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_cnt <= '0;
        end else if (start) begin
            r_cnt <= is_div ? c_div_load : c_mult_load;
        end else if (r_cnt != '0) begin
            r_cnt <= r_cnt - 8'd1;
        end
    end

    assign busy = (r_cnt != '0);

endmodule
`default_nettype wire

// File: rtl/hazard_tracker.sv
`default_nettype none
// ============================================================================
// Module   : hazard_tracker
// Brief    : Decode-stage stall and forward-select generation from a per-stage
//            scoreboard of pending writes plus mult/div occupancy.
// Revision : 1.0 - initial release
// ============================================================================
module hazard_tracker
    import hazard_pkg::*;
#(
    parameter int NSTAGE   = 3,
    parameter int AW       = 5,
    parameter int MULT_CYC = 5,
    parameter int DIV_CYC  = 10
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          d_valid,
    input  logic [AW-1:0] d_rs,
    input  logic [AW-1:0] d_rt,
    input  logic [1:0]    d_tuse_rs,
    input  logic [1:0]    d_tuse_rt,
    input  logic [AW-1:0] d_wa,
    input  logic [1:0]    d_tnew,
    input  logic          d_md_start,
    input  logic          d_md_div,
    input  logic          d_md_use,
    output logic          stall,
    output logic [2:0]    fwd_rs,
    output logic [2:0]    fwd_rt,
    output logic          md_busy
);

    logic [AW-1:0] w_wa   [1:NSTAGE];
    logic [1:0]    w_tnew [1:NSTAGE];
    logic          w_issue;
    logic          w_rs_hit;
    logic          w_rt_hit;
    logic [1:0]    w_rs_tnew;
    logic [1:0]    w_rt_tnew;
    logic          w_rs_stall;
    logic          w_rt_stall;

    assign w_issue = d_valid && !stall;

    genvar k;
    generate
        for (k = 1; k <= NSTAGE; k++) begin : g_stage
            logic [AW-1:0] r_wa;
            logic [1:0]    r_tnew;

            if (k == 1) begin : g_head
                // A stalled or empty decode slot becomes a bubble in stage 1.
                always_ff @(posedge clk or negedge reset) begin
                    if (!reset) begin
                        r_wa   <= '0;
                        r_tnew <= '0;
                    end else if (w_issue) begin
                        r_wa   <= d_wa;
                        r_tnew <= d_tnew;
                    end else begin
                        r_wa   <= '0;
                        r_tnew <= '0;
                    end
                end
            end else begin : g_tail
                always_ff @(posedge clk or negedge reset) begin
                    if (!reset) begin
                        r_wa   <= '0;
                        r_tnew <= '0;
                    end else begin
                        r_wa   <= w_wa[k-1];
                        r_tnew <= sat_dec(w_tnew[k-1]);
                    end
                end
            end

            assign w_wa[k]   = r_wa;
            assign w_tnew[k] = r_tnew;
        end
    endgenerate

    // Youngest stage wins: once an operand has matched, older stages are ignored.
    always_comb begin
        fwd_rs    = FWD_RF;
        fwd_rt    = FWD_RF;
        w_rs_hit  = 1'b0;
        w_rt_hit  = 1'b0;
        w_rs_tnew = 2'd0;
        w_rt_tnew = 2'd0;
        for (int i = 1; i <= NSTAGE; i++) begin
            if (!w_rs_hit && d_rs != '0 && w_wa[i] == d_rs) begin
                w_rs_hit  = 1'b1;
                fwd_rs    = 3'(i);
                w_rs_tnew = w_tnew[i];
            end
            if (!w_rt_hit && d_rt != '0 && w_wa[i] == d_rt) begin
                w_rt_hit  = 1'b1;
                fwd_rt    = 3'(i);
                w_rt_tnew = w_tnew[i];
            end
        end
    end

    assign w_rs_stall = w_rs_hit && (d_tuse_rs != TUSE_NONE) && (d_tuse_rs < w_rs_tnew);
    assign w_rt_stall = w_rt_hit && (d_tuse_rt != TUSE_NONE) && (d_tuse_rt < w_rt_tnew);
    assign stall      = d_valid && (w_rs_stall || w_rt_stall || (d_md_use && md_busy));

    md_busy_counter #(
        .MULT_CYC (MULT_CYC),
        .DIV_CYC  (DIV_CYC)
    ) u_md_busy_counter (
        .start  (w_issue && d_md_start),
        .is_div (d_md_div),
        .busy   (md_busy),
        .clk    (clk),
        .reset  (reset)
    );

endmodule
`default_nettype wire
